// File: rtl/reg_loader.sv
// reg_loader: write-side controller for an 8x8 regMem register file.
// Accepts a byte stream over valid/ready and writes consecutive bytes into
// consecutive registers starting at first_reg, wrapping after register 7.
// Optional readback pass through regMem's two read ports is enabled by
// defining REG_LOADER_VERIFY_EN.
//
// state  | meaning
// IDLE   | waiting for start after reset
// LOAD   | in_ready high, one register written per accepted byte
// FLUSH  | final registered write lands in regMem
// VERIFY | readback of every loaded register, two per cycle
// DONE   | load finished cleanly, holds until start/reset
// ERROR  | readback mismatch, err_reg names the first bad register
module reg_loader (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] first_reg,
    input  logic [3:0] num_regs,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       write,
    output logic [2:0] wR,
    output logic [7:0] dataIn,
    output logic [2:0] opA,
    output logic [2:0] opB,
    input  logic [7:0] operand_a,
    input  logic [7:0] operand_b,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [2:0] err_reg
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_FLUSH  = 3'd2,
        S_VERIFY = 3'd3,
        S_DONE   = 3'd4,
        S_ERROR  = 3'd5
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [3:0] rem_q, rem_d;
    logic       write_q, write_d;
    logic [2:0] wr_q, wr_d;
    logic [7:0] data_q, data_d;

    logic       handshake;
    logic       start_ok;
    logic [3:0] num_sat;

    assign handshake = (state_q == S_LOAD) && in_valid;
    assign start_ok  = start && ((state_q == S_IDLE) || (state_q == S_DONE) ||
                                 (state_q == S_ERROR));
    assign num_sat   = (num_regs > 4'd8) ? 4'd8 : num_regs;

`ifdef REG_LOADER_VERIFY_EN
    logic [7:0] shadow_q [8];
    logic [2:0] start_ptr_q;
    logic [3:0] start_rem_q;
    logic [2:0] err_reg_q, err_reg_d;
    logic [2:0] ptr_inc;

    assign ptr_inc = ptr_q + 3'd1;
`else
    logic unused_operands;
    assign unused_operands = ^{operand_a, operand_b};
`endif

    // Next-state, pointer/remaining-count and write-port decisions.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        write_d = 1'b0;
        wr_d    = wr_q;
        data_d  = data_q;
`ifdef REG_LOADER_VERIFY_EN
        err_reg_d = err_reg_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start_ok) begin
                    ptr_d   = first_reg;
                    rem_d   = num_sat;
                    state_d = (num_sat == 4'd0) ? S_DONE : S_LOAD;
`ifdef REG_LOADER_VERIFY_EN
                    err_reg_d = 3'd0;
`endif
                end
            end
            S_LOAD: begin
                if (handshake) begin
                    write_d = 1'b1;
                    wr_d    = ptr_q;
                    data_d  = in_data;
                    ptr_d   = ptr_q + 3'd1;
                    rem_d   = rem_q - 4'd1;
                    if (rem_q == 4'd1) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
`ifdef REG_LOADER_VERIFY_EN
                state_d = S_VERIFY;
                ptr_d   = start_ptr_q;
                rem_d   = start_rem_q;
`else
                state_d = S_DONE;
`endif
            end
`ifdef REG_LOADER_VERIFY_EN
            S_VERIFY: begin
                // opA is checked first so a double failure reports load order.
                if (operand_a != shadow_q[ptr_q]) begin
                    state_d   = S_ERROR;
                    err_reg_d = ptr_q;
                end else if ((rem_q >= 4'd2) && (operand_b != shadow_q[ptr_inc])) begin
                    state_d   = S_ERROR;
                    err_reg_d = ptr_inc;
                end else if (rem_q <= 4'd2) begin
                    state_d = S_DONE;
                    rem_d   = 4'd0;
                end else begin
                    ptr_d = ptr_q + 3'd2;
                    rem_d = rem_q - 4'd2;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, pointer and registered regMem write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= 3'd0;
            rem_q   <= 4'd0;
            write_q <= 1'b0;
            wr_q    <= 3'd0;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            write_q <= write_d;
            wr_q    <= wr_d;
            data_q  <= data_d;
        end
    end

`ifdef REG_LOADER_VERIFY_EN
    // Shadow copy of accepted bytes plus the start values the readback reloads.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                shadow_q[i] <= 8'h00;
            end
            start_ptr_q <= 3'd0;
            start_rem_q <= 4'd0;
            err_reg_q   <= 3'd0;
        end else begin
            if (handshake) begin
                shadow_q[ptr_q] <= in_data;
            end
            if (start_ok) begin
                start_ptr_q <= first_reg;
                start_rem_q <= num_sat;
            end
            err_reg_q <= err_reg_d;
        end
    end

    assign opA     = (state_q == S_VERIFY) ? ptr_q   : 3'd0;
    assign opB     = (state_q == S_VERIFY) ? ptr_inc : 3'd0;
    assign error   = (state_q == S_ERROR);
    assign err_reg = err_reg_q;
`else
    assign opA     = 3'd0;
    assign opB     = 3'd0;
    assign error   = 1'b0;
    assign err_reg = 3'd0;
`endif

    assign in_ready = (state_q == S_LOAD);
    assign write    = write_q;
    assign wR       = wr_q;
    assign dataIn   = data_q;
    assign busy     = (state_q == S_LOAD) || (state_q == S_FLUSH) || (state_q == S_VERIFY);
    assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_reg_loader.sv
// tb_reg_loader: randomized self-checking bench for reg_loader with a
// behavioural regMem and a register-file reference model.
module tb_reg_loader;

`ifdef REG_LOADER_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset, start, in_valid;
    logic [2:0] first_reg;
    logic [3:0] num_regs;
    logic [7:0] in_data;
    logic       in_ready, write, busy, done, error;
    logic [2:0] wR, opA, opB, err_reg;
    logic [7:0] dataIn, operand_a, operand_b;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    reg_loader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .first_reg (first_reg),
        .num_regs  (num_regs),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .write     (write),
        .wR        (wR),
        .dataIn    (dataIn),
        .opA       (opA),
        .opB       (opB),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .err_reg   (err_reg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural regMem with a corruption hook.
    logic [7:0] mem [8];
    logic       mem_clr   = 1'b0;
    logic       poke      = 1'b0;
    logic [2:0] poke_addr = 3'd0;
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 8; i++) mem[i] <= 8'h00;
        end else begin
            if (write) mem[wR] <= dataIn;
            if (poke) mem[poke_addr] <= 8'h00;
        end
    end
    assign operand_a = mem[opA];
    assign operand_b = mem[opB];

    // Write-port observer.
    int         wr_cyc  [$];
    logic [2:0] wr_addr [$];
    logic [7:0] wr_dat  [$];
    bit         op_nz = 1'b0;
    always @(negedge clk) begin
        if (write === 1'b1) begin
            wr_cyc.push_back(cyc);
            wr_addr.push_back(wR);
            wr_dat.push_back(dataIn);
        end
        if (opA !== 3'd0 || opB !== 3'd0) op_nz = 1'b1;
    end

    logic [7:0] exp_mem [8];
    logic [7:0] src [8];
    bit         any_verify = 1'b0;

    task automatic do_load(input logic [2:0] first, input logic [3:0] num, input int gap_pct,
                           input int gap_after_first, input int abort_after,
                           input int poke_reg, input bit start_noise);
        int n, accepted, gap_left, budget, last_hs, end_at, exp_end, ord, nchk;
        int hs_cyc [$];
        bit ready_bad, hit, exp_err;
        logic [2:0] exp_err_reg;
        n = (num > 4'd8) ? 8 : int'(num);
        wr_cyc.delete(); wr_addr.delete(); wr_dat.delete();
        @(negedge clk);
        start = 1'b1; first_reg = first; num_regs = num; in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        tests++;
        if (error !== 1'b0 || err_reg !== 3'd0) begin
            fails++;
            $display("FAIL start_clear: error=%b err_reg=%0d, expected 0/0", error, err_reg);
        end
        if (n == 0) begin
            tests++;
            if (done !== 1'b1 || busy !== 1'b0) begin
                fails++;
                $display("FAIL zero_done: done=%b busy=%b, expected 1/0", done, busy);
            end
            in_valid = 1'b1;
            repeat (3) @(negedge clk);
            in_valid = 1'b0;
            tests++;
            if (wr_cyc.size() != 0) begin
                fails++;
                $display("FAIL zero_nowrite: %0d writes, expected 0", wr_cyc.size());
            end
            return;
        end
        tests++;
        if (busy !== 1'b1 || done !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL load_entry: busy=%b done=%b in_ready=%b, expected 1/0/1",
                     busy, done, in_ready);
        end
        accepted = 0; gap_left = 0; budget = 400; ready_bad = 1'b0;
        while (accepted < n && budget > 0) begin
            budget--;
            if (in_ready !== 1'b1) ready_bad = 1'b1;
            if (start_noise) begin
                start     = ($urandom_range(0, 4) == 0);
                first_reg = 3'($urandom);
                num_regs  = 4'($urandom);
            end
            if (gap_left == 0 && $urandom_range(0, 99) >= gap_pct) begin
                in_valid = 1'b1;
                in_data  = src[accepted];
                hs_cyc.push_back(cyc);
                accepted++;
                if (accepted == 1) gap_left = gap_after_first;
            end else begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                if (gap_left > 0) gap_left--;
            end
            @(negedge clk);
            in_valid = 1'b0;
            start    = 1'b0;
            if (abort_after > 0 && accepted == abort_after) break;
        end
        tests++;
        if (ready_bad !== 1'b0 || (abort_after == 0 && accepted != n)) begin
            fails++;
            $display("FAIL load_phase: ready_dropped=%b accepted=%0d, expected 0/%0d",
                     ready_bad, accepted, n);
        end
        if (abort_after > 0) begin
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            tests++;
            if (busy !== 1'b0 || in_ready !== 1'b0 || write !== 1'b0 || done !== 1'b0) begin
                fails++;
                $display("FAIL abort_idle: busy=%b in_ready=%b write=%b done=%b, expected 0000",
                         busy, in_ready, write, done);
            end
            n = accepted;
        end else begin
            last_hs = hs_cyc[hs_cyc.size()-1];
            tests++;
            if (in_ready !== 1'b0 || busy !== 1'b1) begin
                fails++;
                $display("FAIL flush_ready: in_ready=%b busy=%b, expected 0/1", in_ready, busy);
            end
            in_valid = 1'b1;
            if (poke_reg >= 0) begin
                poke = 1'b1;
                poke_addr = 3'(poke_reg);
            end
            end_at = -1;
            for (int t = 0; t < 30 && end_at < 0; t++) begin
                @(negedge clk);
                poke    = 1'b0;
                in_data = 8'($urandom);
                if (done === 1'b1 || error === 1'b1) end_at = cyc;
            end
            in_valid = 1'b0;
            hit = 1'b0; ord = 0;
            for (int i = 0; i < n; i++) begin
                if ((int'(first) + i) % 8 == poke_reg) begin
                    hit = 1'b1; ord = i;
                end
            end
            exp_err     = VERIFY && hit && (src[ord] != 8'h00);
            exp_err_reg = exp_err ? 3'(poke_reg) : 3'd0;
            exp_end     = exp_err ? (last_hs + 3 + ord / 2)
                                  : (last_hs + 2 + (VERIFY ? (n + 1) / 2 : 0));
            if (VERIFY) any_verify = 1'b1;
            tests++;
            if (end_at !== exp_end || error !== exp_err || done !== !exp_err ||
                err_reg !== exp_err_reg) begin
                fails++;
                $display("FAIL completion: cyc=%0d done=%b error=%b err_reg=%0d, expected cyc=%0d done=%b error=%b err_reg=%0d",
                         end_at, done, error, err_reg, exp_end, !exp_err, exp_err, exp_err_reg);
            end
        end
        tests++;
        if (wr_cyc.size() != n) begin
            fails++;
            $display("FAIL write_count: %0d writes, expected %0d", wr_cyc.size(), n);
        end
        nchk = (wr_cyc.size() < n) ? wr_cyc.size() : n;
        for (int i = 0; i < nchk; i++) begin
            tests++;
            if (wr_cyc[i] != hs_cyc[i] + 1 || int'(wr_addr[i]) != (int'(first) + i) % 8 ||
                wr_dat[i] !== src[i]) begin
                fails++;
                $display("FAIL write_%0d: cyc=%0d wR=%0d dataIn=%h, expected cyc=%0d wR=%0d dataIn=%h",
                         i, wr_cyc[i], wr_addr[i], wr_dat[i], hs_cyc[i] + 1,
                         (int'(first) + i) % 8, src[i]);
            end
        end
        for (int i = 0; i < n; i++) exp_mem[(int'(first) + i) % 8] = src[i];
        if (abort_after == 0 && poke_reg >= 0) exp_mem[poke_reg] = 8'h00;
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (mem[i] !== exp_mem[i]) begin
                fails++;
                $display("FAIL mem_r%0d: %h, expected %h", i, mem[i], exp_mem[i]);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; first_reg = 3'd0;
        num_regs = 4'd0; in_data = 8'h00; mem_clr = 1'b1;
        for (int i = 0; i < 8; i++) exp_mem[i] = 8'h00;
        repeat (3) @(negedge clk);
        tests++;
        if ({in_ready, write, busy, done, error} !== 5'b0 || wR !== 3'd0 || dataIn !== 8'h00 ||
            opA !== 3'd0 || opB !== 3'd0 || err_reg !== 3'd0) begin
            fails++;
            $display("FAIL reset_outputs: rdy/wr/busy/done/err=%b wR=%0d dataIn=%h opA=%0d opB=%0d err_reg=%0d, expected all 0",
                     {in_ready, write, busy, done, error}, wR, dataIn, opA, opB, err_reg);
        end
        reset = 1'b0; mem_clr = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) src[i] = 8'h10 + 8'(i);
        do_load(3'd0, 4'd8, 0, 0, 0, -1, 1'b0);
        tests++;
        if (mem[3] !== 8'h13) begin
            fails++;
            $display("FAIL b2b_r3: %h, expected 13", mem[3]);
        end
    endtask

    task automatic test_wrap_gap();
        src[0] = 8'hA0; src[1] = 8'hA1; src[2] = 8'hA2;
        do_load(3'd6, 4'd3, 0, 2, 0, -1, 1'b0);
        tests++;
        if (mem[6] !== 8'hA0 || mem[7] !== 8'hA1 || mem[0] !== 8'hA2) begin
            fails++;
            $display("FAIL wrap_regs: r6=%h r7=%h r0=%h, expected A0 A1 A2", mem[6], mem[7], mem[0]);
        end
    endtask

    task automatic test_verify_corrupt();
        src[0] = 8'h55; src[1] = 8'h66; src[2] = 8'h77;
        do_load(3'd2, 4'd3, 0, 0, 0, 3, 1'b0);
    endtask

    task automatic test_zero_and_saturate();
        do_load(3'd5, 4'd0, 0, 0, 0, -1, 1'b0);
        for (int i = 0; i < 8; i++) src[i] = 8'($urandom);
        do_load(3'd3, 4'd12, 0, 0, 0, -1, 1'b0);
    endtask

    task automatic test_reset_mid_load();
        for (int i = 0; i < 8; i++) src[i] = 8'($urandom) | 8'h01;
        do_load(3'($urandom), 4'd5, 0, 0, 2, -1, 1'b0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 14; it++) begin
            for (int i = 0; i < 8; i++) src[i] = 8'($urandom);
            do_load(3'($urandom), 4'($urandom_range(0, 15)), 30, 0, 0,
                    ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1, 1'b1);
        end
    endtask

    task automatic test_read_ports();
        tests++;
        if (op_nz !== (VERIFY && any_verify)) begin
            fails++;
            $display("FAIL read_ports: opA/opB nonzero seen=%b, expected %b", op_nz,
                     VERIFY && any_verify);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_wrap_gap();
        test_verify_corrupt();
        test_zero_and_saturate();
        test_reset_mid_load();
        test_random();
        test_read_ports();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
